// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 LED-matrix scan driver with binary-coded modulation.
//
// Each scan row is sent as CB bit-planes. Each plane goes through three
// steps: shift COLS pixels out of the frame-buffer RAM, latch them, then
// display them for OE_BASE<<plane cycles. All panel pins come straight
// from flops, so they do not glitch.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            start/continue scanning (sampled in IDLE and at frame end)
//   rd_en             frame-buffer read strobe
//   rd_row, rd_col    read address (top-half row; RAM returns row and row+2^ROW_BITS)
//   rd_top, rd_bot    {R,G,B} pixels, CB bits each, valid 1 cycle after rd_en
//   row_addr          panel row select
//   R0,G0,B0,R1,G1,B1 panel colour data for the current bit-plane
//   sclk, LAT, OE     panel shift clock, latch (high), output enable (low)
//   frame_done        one-cycle pulse on the last display cycle of a frame
//   busy              high whenever not IDLE
module hub75_bcm_scan_driver #(
  parameter int  COLS     = 64,
  parameter int  ROW_BITS = 4,
  parameter int  CB       = 4,
  parameter int  OE_BASE  = 8,
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic                rd_en,
  output logic [ROW_BITS-1:0] rd_row,
  output logic [CW-1:0]       rd_col,
  input  logic [3*CB-1:0]     rd_top,
  input  logic [3*CB-1:0]     rd_bot,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                R0,
  output logic                G0,
  output logic                B0,
  output logic                R1,
  output logic                G1,
  output logic                B1,
  output logic                sclk,
  output logic                LAT,
  output logic                OE,
  output logic                frame_done,
  output logic                busy
);

  localparam int KW = $clog2(2*COLS + 2);
  localparam int PW = (CB > 1) ? $clog2(CB) : 1;
  localparam int DW = $clog2(OE_BASE << (CB - 1)) + 1;

  localparam logic [KW-1:0]       K_LAST   = KW'(2*COLS + 1);
  localparam logic [KW-1:0]       K_RD_END = KW'(2*COLS);
  localparam logic [KW-1:0]       K_SCLK0  = KW'(3);
  localparam logic [PW-1:0]       P_LAST   = PW'(CB - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t              state, state_n;
  logic [KW-1:0]       k, k_n;
  logic [PW-1:0]       plane, plane_n;
  logic [ROW_BITS-1:0] row, row_n;
  logic [DW-1:0]       d, d_n;
  logic                take_px;
  logic                rd_en_n, sclk_n, lat_n, oe_n, fd_n, busy_n;
  logic [CW-1:0]       rd_col_n;
  logic [ROW_BITS-1:0] row_addr_n;

  // Last display-counter value for a plane: (OE_BASE << p) - 1.
  function automatic logic [DW-1:0] disp_last(input logic [PW-1:0] p);
    return DW'((OE_BASE << p) - 1);
  endfunction

  // Picks bit p of each colour field, giving {R,G,B}.
  function automatic logic [2:0] plane_bits(input logic [3*CB-1:0] px,
                                            input logic [PW-1:0]   p);
    logic [3*CB-1:0] s;
    s = px >> p;
    return {s[2*CB], s[CB], s[0]};
  endfunction

  assign rd_row = row;

  always_comb begin
    state_n = state;
    k_n     = k;
    plane_n = plane;
    row_n   = row;
    d_n     = d;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = SHIFT;
          k_n     = '0;
          plane_n = '0;
          row_n   = '0;
        end
      end
      SHIFT: begin
        if (k == K_LAST) state_n = LATCH;
        else             k_n     = k + 1'b1;
      end
      LATCH: begin
        state_n = DISPLAY;
        d_n     = '0;
      end
      DISPLAY: begin
        if (d == disp_last(plane)) begin
          k_n = '0;
          if (plane != P_LAST) begin
            plane_n = plane + 1'b1;
            state_n = SHIFT;
          end else begin
            plane_n = '0;
            row_n   = row + 1'b1;
            // Row wrap is the end of frame; only here is enable consulted again.
            if (row == ROW_LAST) state_n = enable ? SHIFT : IDLE;
            else                 state_n = SHIFT;
          end
        end else begin
          d_n = d + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Pixel data is valid on the odd SHIFT cycle after each even-cycle read.
    take_px = (state == SHIFT) && k[0] && (k < K_RD_END);

    // Outputs are decoded from the next state so that they land in flops
    // aligned with the state they describe.
    rd_en_n    = (state_n == SHIFT) && !k_n[0] && (k_n < K_RD_END);
    sclk_n     = (state_n == SHIFT) &&  k_n[0] && (k_n >= K_SCLK0);
    lat_n      = (state_n == LATCH);
    oe_n       = (state_n != DISPLAY);
    busy_n     = (state_n != IDLE);
    rd_col_n   = rd_en_n ? CW'(k_n >> 1) : rd_col;
    row_addr_n = lat_n ? row_n : row_addr;
    fd_n       = (state_n == DISPLAY) && (plane_n == P_LAST) &&
                 (row_n == ROW_LAST) && (d_n == disp_last(plane_n));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      plane      <= '0;
      row        <= '0;
      d          <= '0;
      rd_en      <= 1'b0;
      rd_col     <= '0;
      row_addr   <= '0;
      sclk       <= 1'b0;
      LAT        <= 1'b0;
      OE         <= 1'b1;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      {R0, G0, B0} <= 3'b000;
      {R1, G1, B1} <= 3'b000;
    end else begin
      state      <= state_n;
      k          <= k_n;
      plane      <= plane_n;
      row        <= row_n;
      d          <= d_n;
      rd_en      <= rd_en_n;
      rd_col     <= rd_col_n;
      row_addr   <= row_addr_n;
      sclk       <= sclk_n;
      LAT        <= lat_n;
      OE         <= oe_n;
      frame_done <= fd_n;
      busy       <= busy_n;
      // Colour stage: RAM read data to panel data pins.
      if (take_px) begin
        {R0, G0, B0} <= plane_bits(rd_top, plane);
        {R1, G1, B1} <= plane_bits(rd_bot, plane);
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
module tb_hub75_bcm_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rd_en;
  logic [0:0] rd_row;
  logic [1:0] rd_col;
  logic [5:0] rd_top, rd_bot;
  logic [0:0] row_addr;
  logic       R0, G0, B0, R1, G1, B1;
  logic       sclk, LAT, OE, frame_done, busy;
  logic       col_mode;

  logic        en2;
  logic        rd_en2;
  logic [3:0]  rd_row2;
  logic [5:0]  rd_col2;
  logic [11:0] rd_top2, rd_bot2;
  logic [3:0]  row_addr2;
  logic        R0b, G0b, B0b, R1b, G1b, B1b;
  logic        sclk2, LAT2, OE2, fd2, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hub75_bcm_scan_driver #(.COLS(4), .ROW_BITS(1), .CB(2), .OE_BASE(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_en(rd_en), .rd_row(rd_row),
    .rd_col(rd_col), .rd_top(rd_top), .rd_bot(rd_bot), .row_addr(row_addr),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1), .sclk(sclk),
    .LAT(LAT), .OE(OE), .frame_done(frame_done), .busy(busy));

  hub75_bcm_scan_driver #(.COLS(64), .ROW_BITS(4), .CB(4), .OE_BASE(8)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .rd_en(rd_en2), .rd_row(rd_row2),
    .rd_col(rd_col2), .rd_top(rd_top2), .rd_bot(rd_bot2), .row_addr(row_addr2),
    .R0(R0b), .G0(G0b), .B0(B0b), .R1(R1b), .G1(G1b), .B1(B1b), .sclk(sclk2),
    .LAT(LAT2), .OE(OE2), .frame_done(fd2), .busy(busy2));

  assign rd_top2 = 12'hA5C;
  assign rd_bot2 = 12'h3C1;

  // Frame-buffer model: one-cycle read latency, random junk when not reading.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_top <= col_mode ? {4'b0000, rd_col} : 6'b10_01_11;
      rd_bot <= col_mode ? {1'b0, rd_row, 4'b0000} : 6'b01_10_00;
    end else begin
      rd_top <= 6'($urandom);
      rd_bot <= 6'($urandom);
    end
  end

  // exp = {busy, OE, LAT, sclk, rd_en, rd_row, row_addr, frame_done}
  typedef struct {
    logic       en;
    logic [7:0] exp;
    logic       chk_col;
    logic [5:0] col;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic en, input logic [7:0] e, input logic chk, input logic [5:0] col);
    vec_t v;
    v.en = en; v.exp = e; v.chk_col = chk; v.col = col;
    tbl.push_back(v);
  endtask

  // 10 SHIFT cycles: reads at k=0,2,4,6; sclk at k=3,5,7,9.
  task automatic add_shift(input logic rr, input logic ra, input int p, input logic first_en);
    logic [9:0] en_pat;
    logic [9:0] sc_pat;
    en_pat = 10'b0001010101;
    sc_pat = 10'b1010101000;
    for (int k = 0; k < 10; k++)
      add_vec((k == 0) ? first_en : 1'b0,
              {1'b1, 1'b1, 1'b0, sc_pat[k], en_pat[k], rr, ra, 1'b0},
              sc_pat[k], (p == 0) ? 6'b011_100 : 6'b101_010);
  endtask

  task automatic add_latch(input logic rr, input logic ra);
    add_vec(1'b0, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rr, ra, 1'b0}, 1'b0, 6'b0);
  endtask

  task automatic add_disp(input int n, input logic rr, input logic ra, input logic fd_last);
    for (int i = 0; i < n; i++)
      add_vec(1'b0, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rr, ra, fd_last && (i == n - 1)}, 1'b0, 6'b0);
  endtask

  initial begin
    logic [5:0] prev_col, cur_col;
    logic [1:0] cc;
    logic       prev_ra;
    int         fdt[4];
    int         nfd, gap, ra_chg, ra_bad, cnt;
    int         sc_cnt, run, nrun, nfd2;
    int         runs[4];
    int         fdt2[2];
    logic       lat_seen;

    // Row 0 then row 1, enable high for the first cycle only, then IDLE.
    add_shift(1'b0, 1'b0, 0, 1'b1); add_latch(1'b0, 1'b0); add_disp(2, 1'b0, 1'b0, 1'b0);
    add_shift(1'b0, 1'b0, 1, 1'b0); add_latch(1'b0, 1'b0); add_disp(4, 1'b0, 1'b0, 1'b0);
    add_shift(1'b1, 1'b0, 0, 1'b0); add_latch(1'b1, 1'b1); add_disp(2, 1'b1, 1'b1, 1'b0);
    add_shift(1'b1, 1'b1, 1, 1'b0); add_latch(1'b1, 1'b1); add_disp(4, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 8'b0_1_0_0_0_0_1_0, 1'b0, 6'b0);
    add_vec(1'b0, 8'b0_1_0_0_0_0_1_0, 1'b0, 6'b0);

    rst = 1'b1; enable = 1'b0; col_mode = 1'b0; en2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",
          64'({busy, OE, LAT, sclk, rd_en, rd_row, row_addr, frame_done, R0, G0, B0, R1, G1, B1, rd_col}),
          64'({8'b0_1_0_0_0_0_0_0, 6'b0, 2'b0}));
    rst = 1'b0;
    prev_col = {R0, G0, B0, R1, G1, B1};

    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en;
      @(posedge clk); #1;
      cur_col = {R0, G0, B0, R1, G1, B1};
      check($sformatf("trace[%0d]", i),
            64'({busy, OE, LAT, sclk, rd_en, rd_row, row_addr, frame_done}), 64'(tbl[i].exp));
      if (tbl[i].chk_col)
        check($sformatf("colour_at_sclk[%0d]", i), 64'({prev_col, cur_col}),
              64'({tbl[i].col, tbl[i].col}));
      prev_col = cur_col;
    end

    // Per-column data and read addresses, one full frame.
    col_mode = 1'b1;
    enable = 1'b1;
    for (int j = 0; j < 56; j++) begin
      int r, jj;
      @(posedge clk); #1;
      enable = 1'b0;
      r = j / 28; jj = j % 28;
      if (jj == 3 || jj == 5 || jj == 7 || jj == 9) begin
        cc = 2'((jj - 3) / 2);
        check($sformatf("col_p0[%0d]", j), 64'({B0, R1}), 64'({cc[0], r[0]}));
      end
      if (jj == 16 || jj == 18 || jj == 20 || jj == 22) begin
        cc = 2'((jj - 16) / 2);
        check($sformatf("col_p1[%0d]", j), 64'({B0, R1}), 64'({cc[1], 1'b0}));
      end
      if (jj == 0 || jj == 2 || jj == 4 || jj == 6) begin
        cc = 2'(jj / 2);
        check($sformatf("rd_addr_p0[%0d]", j), 64'({rd_en, rd_row, rd_col}), 64'({1'b1, r[0], cc}));
      end
      if (jj == 13 || jj == 15 || jj == 17 || jj == 19) begin
        cc = 2'((jj - 13) / 2);
        check($sformatf("rd_addr_p1[%0d]", j), 64'({rd_en, rd_row, rd_col}), 64'({1'b1, r[0], cc}));
      end
    end
    @(posedge clk); #1;
    check("idle_after_frame", 64'({busy, OE}), 64'({1'b0, 1'b1}));
    col_mode = 1'b0;

    // Continuous frames with enable held high.
    enable = 1'b1;
    nfd = 0; gap = 0; ra_chg = 0; ra_bad = 0;
    prev_ra = row_addr[0];
    for (int s = 1; s <= 180; s++) begin
      @(posedge clk); #1;
      if (frame_done && nfd < 4) begin fdt[nfd] = s; nfd++; end
      if (!busy) gap++;
      if (row_addr[0] != prev_ra) begin
        ra_chg++;
        if (!LAT) ra_bad++;
      end
      prev_ra = row_addr[0];
    end
    check("fd_count", 64'(nfd), 64'(3));
    check("fd_first", 64'(fdt[0]), 64'(56));
    check("fd_period1", 64'(fdt[1] - fdt[0]), 64'(56));
    check("fd_period2", 64'(fdt[2] - fdt[1]), 64'(56));
    check("no_idle_gap", 64'(gap), 64'(0));
    check("row_addr_only_in_latch", 64'(ra_bad), 64'(0));
    check("row_addr_changes", 64'(ra_chg >= 4), 64'(1));

    // Drop enable in row 0: the frame must finish before going idle.
    enable = 1'b0;
    cnt = 0;
    while (!frame_done && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("drop_enable_fd_wait", 64'(cnt), 64'(44));
    @(posedge clk); #1;
    check("drop_enable_idle", 64'({busy, OE, sclk, LAT}), 64'({1'b0, 1'b1, 1'b0, 1'b0}));

    // Asynchronous reset during row-1 DISPLAY.
    enable = 1'b1;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_display", 64'({OE, row_addr}), 64'({1'b0, 1'b1}));
    #2 rst = 1'b1;
    #1;
    check("async_reset", 64'({OE, LAT, sclk, row_addr, busy, rd_en, frame_done}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("restart_shift", 64'({busy, rd_en, rd_row, rd_col}), 64'({1'b1, 1'b1, 1'b0, 2'b00}));
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
    end
    check("restart_latch", 64'({LAT, row_addr}), 64'({1'b1, 1'b0}));
    cnt = 0;
    for (int j = 11; j <= 13; j++) begin
      @(posedge clk); #1;
      if (!OE) cnt++;
    end
    check("restart_plane0_len", 64'(cnt), 64'(2));
    enable = 1'b0;

    // Full-size configuration.
    en2 = 1'b1;
    sc_cnt = 0; run = 0; nrun = 0; nfd2 = 0; lat_seen = 1'b0;
    for (int s = 1; s <= 25000 && nfd2 < 2; s++) begin
      @(posedge clk); #1;
      if (!lat_seen) begin
        if (sclk2) sc_cnt++;
        if (LAT2) lat_seen = 1'b1;
      end
      if (!OE2) run++;
      else if (run > 0) begin
        if (nrun < 4) runs[nrun] = run;
        nrun++;
        run = 0;
      end
      if (fd2) begin fdt2[nfd2] = s; nfd2++; end
    end
    check("big_sclk_pulses", 64'(sc_cnt), 64'(64));
    check("big_disp_p0", 64'(runs[0]), 64'(8));
    check("big_disp_p1", 64'(runs[1]), 64'(16));
    check("big_disp_p2", 64'(runs[2]), 64'(32));
    check("big_disp_p3", 64'(runs[3]), 64'(64));
    check("big_fd_count", 64'(nfd2), 64'(2));
    check("big_fd_first", 64'(fdt2[0]), 64'(10304));
    check("big_fd_period", 64'(fdt2[1] - fdt2[0]), 64'(10304));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_scan_driver.md
Name: hub75_bcm_scan_driver

Overview:
- Parametrised HUB75 LED-matrix scan driver; successor to the fixed 64-column, 1-bit test-pattern driver.
- Reads pixel data from an external frame-buffer RAM instead of hard-coded patterns.
- Supports configurable columns, scan rows and colour depth, using binary-coded modulation (BCM) for brightness.
- Sits between the frame buffer / game renderer and the panel connector pins.

Parameters:
COLS, 64, pixels per shifted row (>=2)
ROW_BITS, 4, scan-row address width; panel height = 2*2^ROW_BITS
CB, 4, colour bits per channel (1..8); one bit-plane per bit
OE_BASE, 8, clk cycles of display for plane 0 (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  run scanning; sampled only in IDLE and at end of frame
rd_en  out  1  frame-buffer read strobe
rd_row  out  ROW_BITS  top-half row being read; RAM returns row and row+2^ROW_BITS
rd_col  out  CW  column read, CW = max(1,clog2(COLS))
rd_top  in  3*CB  top pixel {R,G,B}, each CB bits, R in MSBs; valid exactly 1 cycle after rd_en
rd_bot  in  3*CB  bottom pixel, same layout and timing
row_addr  out  ROW_BITS  panel row select (D,C,B,A order)
R0,G0,B0,R1,G1,B1  out  1 each  panel colour data, current plane bit
sclk  out  1  panel shift clock
LAT  out  1  panel latch, active-high
OE  out  1  panel output enable, active-low (1 = blanked)
frame_done  out  1  one-cycle pulse at end of frame
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (async, immediate, including mid-operation): state IDLE, OE=1, LAT=0, sclk=0, rd_en=0, all colour bits 0, row_addr=0, rd_row=0, rd_col=0, frame_done=0, busy=0, row counter 0, plane counter 0.
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: OE=1. If enable=1, go to SHIFT next cycle with row=0, plane=0.
- SHIFT lasts 2*COLS+2 cycles, indexed k=0..2*COLS+1, with OE=1 throughout.
  - For column c: rd_en=1 and rd_col=c at k=2c; rd_en=0 on odd k.
  - At the end of k=2c+1, the colour outputs register bit [plane] of each field: R0=rd_top[2CB+plane], G0=rd_top[CB+plane], B0=rd_top[plane]; R1/G1/B1 are taken the same way from rd_bot.
  - sclk=1 at k=2c+3 and 0 otherwise, so data is stable one full cycle before each rising edge. Exactly COLS sclk pulses per SHIFT.
  - rd_row = current row throughout.
- LATCH (1 cycle): LAT=1, OE=1, sclk=0. row_addr is updated to the current row in this cycle.
- DISPLAY: OE=0 for exactly OE_BASE<<plane cycles; LAT=0, sclk=0.
  - On exit: if plane<CB-1, plane+1 and go to SHIFT (same row).
  - Else plane=0 and the row increments. Wrap-around from 2^ROW_BITS-1 to 0 is the end of frame.
- End of frame: frame_done=1 on the last DISPLAY cycle of the last row. Next state is SHIFT (row 0) if enable=1, else IDLE. There is no IDLE cycle between back-to-back frames.
- enable changes mid-frame: ignored until end of frame.
- Row time = CB*(2*COLS+3) + OE_BASE*(2^CB-1) cycles. Frame time = 2^ROW_BITS * row time.
- Arithmetic:
  - Display counter width is clog2(OE_BASE<<(CB-1))+1; all counters are unsigned with no overflow.
  - Column counter wraps only via the state transition.
- Data validity: rd_top/rd_bot are sampled only on cycles immediately after rd_en; values at other times must have no effect on outputs.

Test Plan (config COLS=4, ROW_BITS=1, CB=2, OE_BASE=2 unless stated; row time 28, frame 56):
- Reset then enable=1 for 1 cycle -> IDLE 1 cycle, SHIFT 10 cycles, exactly 4 sclk pulses, LAT high on cycle 12, OE low cycles 13-14 (plane 0), then OE low 4 cycles for plane 1.
- RAM returns rd_top=6'b10_01_11 for all columns -> plane 0 shifts R0=0,G0=1,B0=1; plane 1 shifts R0=1,G0=0,B0=1. Each bit is stable on every sclk rising edge.
- enable held high -> frame_done pulses every 56 cycles; row_addr sequence 0,1,0,... changes only in LATCH cycles.
- enable dropped in the middle of row 0 -> frame completes (frame_done asserted), then IDLE with busy=0 and OE=1.
- rst asserted during DISPLAY with OE=0 -> same cycle OE=1, LAT=0, sclk=0, row_addr=0; after release, restarts from row 0, plane 0.
- Config COLS=64, ROW_BITS=4, CB=4, OE_BASE=8 -> 64 sclk pulses per SHIFT, DISPLAY lengths 8/16/32/64, frame_done period 16*(4*131+120)=10304 cycles.
